// File: rtl/regfile_dump.sv
// regfile_dump: freezes the core, waits for the ROB to drain, then streams every
// architectural register out over a valid/ready interface while accumulating a
// 32-bit wrapping checksum of the transferred values.
//
// Ports
//   clk, reset          single clock, asynchronous active-high reset
//   dump_req            one-cycle request to start a dump (honoured only when idle)
//   rob_empty           no instructions in flight
//   freeze              stalls fetch/dispatch while a dump is in progress
//   rf_raddr, rf_rdata  debug read port into the register file (combinational data)
//   out_valid, out_ready, out_idx, out_data   dump stream
//   dump_done           one-cycle pulse at the end of a dump
//   dump_err            sticky: ROB failed to drain within DRAIN_MAX cycles
//   checksum            running sum of transferred beats, modulo 2^32
module regfile_dump #(
   parameter int unsigned NUM_REGS  = 32,
   parameter int unsigned DRAIN_MAX = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dump_req,
   input  logic        rob_empty,
   output logic        freeze,
   output logic [4:0]  rf_raddr,
   input  logic [31:0] rf_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_idx,
   output logic [31:0] out_data,
   output logic        dump_done,
   output logic        dump_err,
   output logic [31:0] checksum
);

   localparam int unsigned CntW    = $clog2(DRAIN_MAX) + 1;
   localparam logic [4:0]  LastIdx = 5'(NUM_REGS - 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DRAIN_MAX - 1);

   typedef enum logic [2:0] {StIdle, StDrain, StLoad, StSend, StDone} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [4:0]        idx_q, idx_d;
   logic [4:0]        out_idx_q, out_idx_d;
   logic [31:0]       out_data_q, out_data_d;
   logic [31:0]       checksum_q, checksum_d;
   logic              err_q, err_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      out_idx_d  = out_idx_q;
      out_data_d = out_data_q;
      checksum_d = checksum_q;
      err_d      = err_q;
      unique case (state_q)
         StIdle: begin
            if (dump_req) begin
               state_d    = StDrain;
               err_d      = 1'b0;
               checksum_d = '0;
               idx_d      = '0;
               cnt_d      = '0;
            end
         end
         StDrain: begin
            if (rob_empty) begin
               state_d = StLoad;
            end else if (cnt_q == CntLast) begin
               // Timeout: give up without producing any beats.
               err_d   = 1'b1;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StLoad: begin
            // rf_raddr already presents idx, so rf_rdata is the value for idx.
            out_data_d = rf_rdata;
            out_idx_d  = idx_q;
            state_d    = StSend;
         end
         StSend: begin
            if (out_ready) begin
               checksum_d = checksum_q + out_data_q;
               if (idx_q == LastIdx) begin
                  state_d = StDone;
               end else begin
                  idx_d   = idx_q + 5'd1;
                  state_d = StLoad;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         idx_q      <= '0;
         out_idx_q  <= '0;
         out_data_q <= '0;
         checksum_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         out_idx_q  <= out_idx_d;
         out_data_q <= out_data_d;
         checksum_q <= checksum_d;
         err_q      <= err_d;
      end
   end

   // Decoded straight from the state register so reset drops them immediately.
   assign freeze    = (state_q != StIdle);
   assign out_valid = (state_q == StSend);
   assign dump_done = (state_q == StDone);
   assign rf_raddr  = idx_q;
   assign out_idx   = out_idx_q;
   assign out_data  = out_data_q;
   assign checksum  = checksum_q;
   assign dump_err  = err_q;

endmodule

// File: tb/tb_regfile_dump.sv
module tb_regfile_dump;

   localparam int unsigned DRAIN_MAX = 1024;

   logic        clk;
   logic        reset;
   logic        dump_req;
   logic        rob_empty;
   logic        freeze;
   logic [4:0]  rf_raddr;
   logic [31:0] rf_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_idx;
   logic [31:0] out_data;
   logic        dump_done;
   logic        dump_err;
   logic [31:0] checksum;

   regfile_dump #(
      .NUM_REGS  (32),
      .DRAIN_MAX (DRAIN_MAX)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .dump_req  (dump_req),
      .rob_empty (rob_empty),
      .freeze    (freeze),
      .rf_raddr  (rf_raddr),
      .rf_rdata  (rf_rdata),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_data  (out_data),
      .dump_done (dump_done),
      .dump_err  (dump_err),
      .checksum  (checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model with combinational read.
   logic [31:0] rf [32];
   assign rf_rdata = rf[rf_raddr];

   typedef struct packed {
      logic [4:0]  idx;
      logic [31:0] data;
   } beat_t;

   beat_t       sb [$];
   logic [31:0] exp_sum;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int req_edge = 0;
   int t_valid  = -1;
   int t_done   = -1;
   int beats    = 0;
   int done_cnt = 0;
   int done0    = 0;

   logic        prev_stall = 1'b0;
   logic [31:0] stall_data;
   logic [4:0]  stall_idx;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic push_range(input int n);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b.idx  = 5'(i);
         b.data = rf[i];
         sb.push_back(b);
         exp_sum = exp_sum + rf[i];
      end
   endtask

   // Samples mid-cycle, scores any transfer, then advances past one rising edge.
   task automatic tick();
      beat_t b;
      @(negedge clk);
      if (prev_stall) begin
         chk("hold_data", out_data, stall_data);
         chk("hold_idx", {27'd0, out_idx}, {27'd0, stall_idx});
      end
      if (out_valid && out_ready) begin
         beats++;
         checks++;
         assert (sb.size() > 0) else begin
            failures++;
            $error("FAIL beat_extra observed=beat idx %0d expected=no beat", out_idx);
         end
         if (sb.size() > 0) begin
            b = sb.pop_front();
            chk("beat_idx", {27'd0, out_idx}, {27'd0, b.idx});
            chk("beat_data", out_data, b.data);
         end
      end
      prev_stall = out_valid && !out_ready;
      stall_data = out_data;
      stall_idx  = out_idx;
      if (dump_done) done_cnt++;
      if (dump_done && t_done < 0) t_done = cyc;
      if (out_valid && t_valid < 0) t_valid = cyc;
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic start_dump();
      dump_req = 1'b1;
      tick();
      req_edge = cyc;
      dump_req = 1'b0;
      t_valid  = -1;
      t_done   = -1;
   endtask

   task automatic wait_done(input int max);
      for (int i = 0; i < max; i++) begin
         if (t_done >= 0) break;
         tick();
      end
      chk1("done_timeout", t_done >= 0, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=no finish expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      reset     = 1'b1;
      dump_req  = 1'b0;
      rob_empty = 1'b1;
      out_ready = 1'b1;
      exp_sum   = '0;
      for (int i = 0; i < 32; i++) rf[i] = '0;
      rf[1] = 32'd6;
      rf[2] = 32'd2;
      rf[3] = 32'd12;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      chk1("rst_freeze", freeze, 1'b0);
      chk1("rst_valid", out_valid, 1'b0);
      chk1("rst_done", dump_done, 1'b0);
      chk1("rst_err", dump_err, 1'b0);
      chk("rst_checksum", checksum, 32'd0);
      chk("rst_raddr", {27'd0, rf_raddr}, 32'd0);
      chk("rst_out_idx", {27'd0, out_idx}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      reset = 1'b0;

      // Basic dump, requested on the first edge after reset release
      beats = 0;
      done0 = done_cnt;
      push_range(32);
      start_dump();
      chk1("a_freeze", freeze, 1'b1);
      wait_done(200);
      chk("a_done_lat", 32'(t_done - req_edge), 32'd65);
      chk("a_beats", 32'(beats), 32'd32);
      chk("a_sb_empty", 32'(sb.size()), 32'd0);
      chk("a_checksum", checksum, 32'd20);
      chk1("a_err", dump_err, 1'b0);
      chk1("a_freeze_off", freeze, 1'b0);
      chk1("a_done_low", dump_done, 1'b0);
      repeat (4) tick();
      chk("a_done_pulses", 32'(done_cnt - done0), 32'd1);
      chk("a_checksum_hold", checksum, 32'd20);

      // Slow drain: ROB busy for 10 cycles after the request
      for (int i = 0; i < 32; i++) rf[i] = $urandom();
      rf[0]     = 32'hA5A5_0000;
      exp_sum   = '0;
      beats     = 0;
      done0     = done_cnt;
      push_range(32);
      rob_empty = 1'b0;
      start_dump();
      for (int i = 0; i < 10; i++) begin
         tick();
         chk1("b_freeze_drain", freeze, 1'b1);
      end
      rob_empty = 1'b1;
      wait_done(200);
      chk("b_valid_lat", 32'(t_valid - req_edge), 32'd12);
      chk("b_beats", 32'(beats), 32'd32);
      chk("b_checksum", checksum, exp_sum);
      chk1("b_err", dump_err, 1'b0);
      chk("b_done_pulses", 32'(done_cnt - done0), 32'd1);

      // Drain timeout
      beats     = 0;
      done0     = done_cnt;
      rob_empty = 1'b0;
      start_dump();
      wait_done(DRAIN_MAX + 100);
      chk("c_done_lat", 32'(t_done - req_edge), 32'(DRAIN_MAX));
      chk("c_valid_seen", 32'(t_valid), 32'hFFFF_FFFF);
      chk("c_beats", 32'(beats), 32'd0);
      chk1("c_err", dump_err, 1'b1);
      tick();
      chk1("c_freeze_off", freeze, 1'b0);
      chk("c_done_pulses", 32'(done_cnt - done0), 32'd1);
      chk1("c_err_sticky", dump_err, 1'b1);
      rob_empty = 1'b1;

      // Random backpressure with a wrapping checksum
      for (int i = 0; i < 32; i++) rf[i] = '0;
      rf[1]   = 32'd1;
      rf[2]   = 32'hFFFF_FFFF;
      exp_sum = '0;
      beats   = 0;
      done0   = done_cnt;
      push_range(32);
      start_dump();
      chk1("d_err_cleared", dump_err, 1'b0);
      guard = 0;
      while (t_done < 0 && guard < 2000) begin
         out_ready = 1'($urandom_range(0, 1));
         tick();
         guard++;
      end
      out_ready = 1'b1;
      chk1("d_done_seen", t_done >= 0, 1'b1);
      chk("d_beats", 32'(beats), 32'd32);
      chk("d_sb_empty", 32'(sb.size()), 32'd0);
      chk("d_checksum", checksum, 32'd0);
      chk("d_done_pulses", 32'(done_cnt - done0), 32'd1);

      // Reset during SEND of idx 7, then a fresh dump
      for (int i = 0; i < 32; i++) rf[i] = $urandom();
      exp_sum = '0;
      beats   = 0;
      push_range(7);
      start_dump();
      guard = 0;
      while (beats < 7 && guard < 200) begin
         tick();
         guard++;
      end
      out_ready = 1'b0;
      tick();
      chk1("e_in_send", out_valid, 1'b1);
      chk("e_send_idx", {27'd0, out_idx}, 32'd7);
      reset = 1'b1;
      #1;
      chk1("e_rst_valid", out_valid, 1'b0);
      chk1("e_rst_freeze", freeze, 1'b0);
      chk("e_rst_checksum", checksum, 32'd0);
      chk("e_rst_data", out_data, 32'd0);
      prev_stall = 1'b0;
      tick();
      tick();
      reset     = 1'b0;
      out_ready = 1'b1;
      chk("e_beats_aborted", 32'(beats), 32'd7);
      chk("e_sb_empty_abort", 32'(sb.size()), 32'd0);
      exp_sum = '0;
      beats   = 0;
      done0   = done_cnt;
      push_range(32);
      start_dump();
      chk("e_checksum_clr", checksum, 32'd0);
      wait_done(200);
      chk("e_beats", 32'(beats), 32'd32);
      chk("e_checksum", checksum, exp_sum);
      chk("e_done_pulses", 32'(done_cnt - done0), 32'd1);

      // dump_req during SEND is ignored
      exp_sum = '0;
      beats   = 0;
      done0   = done_cnt;
      push_range(32);
      start_dump();
      guard = 0;
      while (t_valid < 0 && guard < 50) begin
         tick();
         guard++;
      end
      tick();
      dump_req = 1'b1;
      tick();
      dump_req = 1'b0;
      wait_done(200);
      repeat (6) tick();
      chk("f_beats", 32'(beats), 32'd32);
      chk("f_sb_empty", 32'(sb.size()), 32'd0);
      chk("f_done_pulses", 32'(done_cnt - done0), 32'd1);
      chk1("f_freeze_off", freeze, 1'b0);
      chk("f_checksum", checksum, exp_sum);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 SHALL provide parameter NUM_REGS, default 32, the number of architectural registers dumped (x0..x31).
REQ-002 SHALL provide parameter DRAIN_MAX, default 1024, the maximum number of cycles spent waiting for the ROB to empty.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port dump_req, input, 1, a one-cycle request to start a register dump.
REQ-006 SHALL have port rob_empty, input, 1, high when no instructions are in flight.
REQ-007 SHALL have port freeze, output, 1, which stalls fetch/dispatch in the core while high.
REQ-008 SHALL have port rf_raddr, output, 5, the debug read address into the architectural register file.
REQ-009 SHALL have port rf_rdata, input, 32, the combinational read data for rf_raddr.
REQ-010 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_idx (output, 5) and out_data (output, 32), which form the dump stream.
REQ-011 SHALL have ports dump_done (output, 1, one-cycle pulse), dump_err (output, 1, sticky drain timeout) and checksum (output, 32, running sum).

Function
REQ-012 SHALL implement the states IDLE, DRAIN, LOAD, SEND and DONE.
REQ-013 IDLE: dump_req=1 SHALL transition to DRAIN next cycle, clear dump_err and checksum, set idx=0 and start the drain counter at 0.
REQ-014 DRAIN: freeze SHALL be 1; rob_empty=1 SHALL transition to LOAD; otherwise the counter SHALL increment.
REQ-015 DRAIN: counter==DRAIN_MAX-1 with rob_empty=0 SHALL set dump_err=1 and transition to DONE, with no stream output.
REQ-016 LOAD: rf_raddr SHALL equal idx; at the clock edge out_data<=rf_rdata and out_idx<=idx; transition to SEND.
REQ-017 SEND: out_valid SHALL be 1, and out_data/out_idx SHALL be held stable until out_ready=1.
REQ-018 SEND handshake: a beat transfers on the edge where out_valid&out_ready; at that edge checksum<=checksum+out_data modulo 2^32 (carry dropped).
REQ-019 SEND transfer: if idx==NUM_REGS-1 the next state SHALL be DONE; else idx SHALL increment and the next state SHALL be LOAD.
REQ-020 Each register SHALL cost a minimum of 2 cycles, giving 2*NUM_REGS cycles from the first LOAD to DONE with out_ready tied high.
REQ-021 DONE: dump_done SHALL be 1 for exactly one cycle, then IDLE; freeze SHALL be 1 in DRAIN, LOAD, SEND and DONE, and 0 in IDLE.
REQ-022 dump_req while not in IDLE SHALL be ignored.
REQ-023 Register 0 SHALL be dumped as read; the block applies no forcing.
REQ-024 out_valid SHALL never be deasserted in SEND before the transfer.
REQ-025 checksum and dump_err SHALL hold their values in IDLE until the next accepted dump_req.

Reset
REQ-026 reset=1 SHALL asynchronously force IDLE, freeze=0, out_valid=0, dump_done=0, dump_err=0, checksum=0, idx=0, rf_raddr=0, out_idx=0 and out_data=0.
REQ-027 reset asserted mid-dump (any state) SHALL abort without emitting further beats; freeze SHALL drop in the same cycle as reset.
REQ-028 The block SHALL accept a new dump_req on the first rising clock edge after reset deasserts.

Verification
REQ-029 Preload x1=6, x2=2, x3=12, others 0; rob_empty=1; pulse dump_req; out_ready=1 -> 32 beats with idx 0..31 in order; checksum=20; dump_done 65 cycles after DRAIN entry.
REQ-030 rob_empty held low for 10 cycles after dump_req -> freeze=1 throughout; first out_valid 12 cycles after the request edge; dump_err=0.
REQ-031 rob_empty never asserted -> dump_err=1 after DRAIN_MAX cycles, no out_valid, one dump_done pulse, freeze=0 afterwards.
REQ-032 out_ready toggled randomly, x2=0xFFFFFFFF and x1=1 -> out_data stable while stalled; no beat lost or duplicated; checksum=0 (wraps).
REQ-033 reset asserted during SEND of idx 7 -> out_valid=0 and freeze=0 immediately; a fresh dump_req restarts at idx 0 with checksum cleared.
REQ-034 dump_req pulsed during SEND -> ignored; exactly 32 beats and one dump_done.
